// File: rtl/floo_narrow_wide_endpoint.sv
// Narrow/wide network endpoint: ejection FIFOs, injection spill buffers, flush, misroute check.
// Defining FLOO_EP_PERF_EN adds six 32-bit traffic counters on perf_cnt_o.

package floo_narrow_wide_flit_pkg;
    localparam int unsigned FlitIdWidth = 4;
    typedef logic [FlitIdWidth-1:0] flit_id_t;
    typedef struct packed {
        flit_id_t dst_id;
        flit_id_t src_id;
    } hdr_t;
    typedef struct packed { hdr_t hdr; logic [39:0]  payload; } narrow_req_data_t;
    typedef struct packed { hdr_t hdr; logic [31:0]  payload; } narrow_rsp_data_t;
    typedef struct packed { hdr_t hdr; logic [127:0] payload; } wide_data_t;
    typedef struct packed { logic valid; logic ready; narrow_req_data_t data; } narrow_req_flit_t;
    typedef struct packed { logic valid; logic ready; narrow_rsp_data_t data; } narrow_rsp_flit_t;
    typedef struct packed { logic valid; logic ready; wide_data_t data; } wide_flit_t;
endpackage

module floo_ep_fifo #(
    parameter int unsigned Depth = 2,
    parameter type data_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output data_t out_data
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    data_t mem [Depth];
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] cnt;
    logic push, pop;

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign in_ready  = (cnt != CntW'(Depth));
    assign out_valid = (cnt != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop)  rd_ptr <= inc(rd_ptr);
            cnt <= cnt + CntW'(push) - CntW'(pop);
        end
    end

    // Storage carries no reset; validity is tracked by cnt alone.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

module floo_narrow_wide_endpoint
    import floo_narrow_wide_flit_pkg::*;
#(
    parameter int unsigned EjFifoDepth = 2,
    parameter int unsigned IdWidth = floo_narrow_wide_flit_pkg::FlitIdWidth,
    parameter type id_t = logic [IdWidth-1:0]
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  id_t              id_i,
    input  narrow_req_flit_t narrow_req_i,
    output narrow_req_flit_t narrow_req_o,
    input  narrow_rsp_flit_t narrow_rsp_i,
    output narrow_rsp_flit_t narrow_rsp_o,
    input  wide_flit_t       wide_i,
    output wide_flit_t       wide_o,
    output logic             ej_narrow_req_valid_o,
    input  logic             ej_narrow_req_ready_i,
    output narrow_req_data_t ej_narrow_req_data_o,
    output logic             ej_narrow_rsp_valid_o,
    input  logic             ej_narrow_rsp_ready_i,
    output narrow_rsp_data_t ej_narrow_rsp_data_o,
    output logic             ej_wide_valid_o,
    input  logic             ej_wide_ready_i,
    output wide_data_t       ej_wide_data_o,
    input  logic             inj_narrow_req_valid_i,
    output logic             inj_narrow_req_ready_o,
    input  narrow_req_data_t inj_narrow_req_data_i,
    input  logic             inj_narrow_rsp_valid_i,
    output logic             inj_narrow_rsp_ready_o,
    input  narrow_rsp_data_t inj_narrow_rsp_data_i,
    input  logic             inj_wide_valid_i,
    output logic             inj_wide_ready_o,
    input  wide_data_t       inj_wide_data_i,
    output logic [2:0]       misroute_o,
    input  logic             flush_i,
    output logic             flush_done_o,
    output logic [5:0][31:0] perf_cnt_o
);
    typedef enum logic [1:0] {IDLE, DRAIN, DONE} flush_state_e;

    flush_state_e state;
    logic idle_q, done_q;
    logic [2:0] mis_q;

    logic nr_ej_rdy, rs_ej_rdy, wd_ej_rdy;
    logic nr_sp_vld, rs_sp_vld, wd_sp_vld;
    logic nr_sp_rdy, rs_sp_rdy, wd_sp_rdy;
    narrow_req_data_t nr_sp_data;
    narrow_rsp_data_t rs_sp_data;
    wide_data_t       wd_sp_data;
    logic nr_acc, rs_acc, wd_acc, inj_empty;

    floo_ep_fifo #(.Depth(EjFifoDepth), .data_t(narrow_req_data_t)) i_nr_ej (
        .clk_i, .rst_ni,
        .in_valid(narrow_req_i.valid), .in_ready(nr_ej_rdy), .in_data(narrow_req_i.data),
        .out_valid(ej_narrow_req_valid_o), .out_ready(ej_narrow_req_ready_i),
        .out_data(ej_narrow_req_data_o));
    floo_ep_fifo #(.Depth(EjFifoDepth), .data_t(narrow_rsp_data_t)) i_rs_ej (
        .clk_i, .rst_ni,
        .in_valid(narrow_rsp_i.valid), .in_ready(rs_ej_rdy), .in_data(narrow_rsp_i.data),
        .out_valid(ej_narrow_rsp_valid_o), .out_ready(ej_narrow_rsp_ready_i),
        .out_data(ej_narrow_rsp_data_o));
    floo_ep_fifo #(.Depth(EjFifoDepth), .data_t(wide_data_t)) i_wd_ej (
        .clk_i, .rst_ni,
        .in_valid(wide_i.valid), .in_ready(wd_ej_rdy), .in_data(wide_i.data),
        .out_valid(ej_wide_valid_o), .out_ready(ej_wide_ready_i),
        .out_data(ej_wide_data_o));

    // Injection uses a 2-deep queue as the spill register; flush gates its input.
    floo_ep_fifo #(.Depth(2), .data_t(narrow_req_data_t)) i_nr_inj (
        .clk_i, .rst_ni,
        .in_valid(inj_narrow_req_valid_i & idle_q), .in_ready(nr_sp_rdy),
        .in_data(inj_narrow_req_data_i),
        .out_valid(nr_sp_vld), .out_ready(narrow_req_i.ready), .out_data(nr_sp_data));
    floo_ep_fifo #(.Depth(2), .data_t(narrow_rsp_data_t)) i_rs_inj (
        .clk_i, .rst_ni,
        .in_valid(inj_narrow_rsp_valid_i & idle_q), .in_ready(rs_sp_rdy),
        .in_data(inj_narrow_rsp_data_i),
        .out_valid(rs_sp_vld), .out_ready(narrow_rsp_i.ready), .out_data(rs_sp_data));
    floo_ep_fifo #(.Depth(2), .data_t(wide_data_t)) i_wd_inj (
        .clk_i, .rst_ni,
        .in_valid(inj_wide_valid_i & idle_q), .in_ready(wd_sp_rdy),
        .in_data(inj_wide_data_i),
        .out_valid(wd_sp_vld), .out_ready(wide_i.ready), .out_data(wd_sp_data));

    assign narrow_req_o = '{valid: nr_sp_vld, ready: nr_ej_rdy, data: nr_sp_data};
    assign narrow_rsp_o = '{valid: rs_sp_vld, ready: rs_ej_rdy, data: rs_sp_data};
    assign wide_o       = '{valid: wd_sp_vld, ready: wd_ej_rdy, data: wd_sp_data};

    assign inj_narrow_req_ready_o = nr_sp_rdy & idle_q;
    assign inj_narrow_rsp_ready_o = rs_sp_rdy & idle_q;
    assign inj_wide_ready_o       = wd_sp_rdy & idle_q;

    assign nr_acc    = narrow_req_i.valid & nr_ej_rdy;
    assign rs_acc    = narrow_rsp_i.valid & rs_ej_rdy;
    assign wd_acc    = wide_i.valid & wd_ej_rdy;
    assign inj_empty = ~(nr_sp_vld | rs_sp_vld | wd_sp_vld);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mis_q <= '0;
        end else begin
            mis_q <= {wd_acc & (wide_i.data.hdr.dst_id != id_i),
                      rs_acc & (narrow_rsp_i.data.hdr.dst_id != id_i),
                      nr_acc & (narrow_req_i.data.hdr.dst_id != id_i)};
        end
    end
    assign misroute_o = mis_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= IDLE;
            idle_q <= 1'b1;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (flush_i) begin
                    state  <= DRAIN;
                    idle_q <= 1'b0;
                end
                DRAIN: if (!flush_i) begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                end else if (inj_empty) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                DONE: if (!flush_i) begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign flush_done_o = done_q;

`ifdef FLOO_EP_PERF_EN
    logic [5:0] perf_inc;
    logic [5:0][31:0] perf_q;
    assign perf_inc = {wd_acc, rs_acc, nr_acc,
                       inj_wide_valid_i & inj_wide_ready_o,
                       inj_narrow_rsp_valid_i & inj_narrow_rsp_ready_o,
                       inj_narrow_req_valid_i & inj_narrow_req_ready_o};
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (perf_inc[i]) perf_q[i] <= perf_q[i] + 32'd1;
            end
        end
    end
    assign perf_cnt_o = perf_q;
`else
    assign perf_cnt_o = '0;
`endif
endmodule
